// File: rtl/add_sub_pipe.sv
// add_sub_pipe: pipelined two's-complement adder/subtractor.
//
// The WIDTH-bit carry chain is cut into STAGES segments of SEG bits. Stage k
// adds segment k of the operands with the carry from stage k-1 and registers:
//   - the operand bits not yet consumed (shifted down, so the next segment is
//     always at bit 0; the top bit of what remains is the operand sign),
//   - the sum bits completed so far (growing by SEG bits per stage),
//   - the carry out of the segment.
// The last stage registers the full sum plus cout/ovf/zero, and those
// registers only change when that stage loads, so outputs are stable across
// stalls and bubbles. Every stage has its own valid bit, so any stage can hold
// a bubble and a stalled pipe fills up from the back before in_ready drops.
module add_sub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SEG = WIDTH / STAGES;

    // valid_vec[k]: stage k holds a bundle.
    // free_vec[k] : stage k may capture this cycle (empty, or its bundle leaves).
    // up_valid[k] : the producer feeding stage k has a bundle for it.
    logic [STAGES-1:0] valid_vec;
    logic [STAGES-1:0] free_vec;
    logic [STAGES-1:0] up_valid;

    // Backward "may move" chain from the consumer towards the input; it only
    // depends on registered valid bits and out_ready, never on in_valid.
    always_comb begin
        logic down;
        free_vec = '0;
        down     = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            free_vec[k] = !valid_vec[k] || down;
            down        = free_vec[k];
        end
    end

    assign in_ready  = free_vec[0];
    assign out_valid = valid_vec[STAGES-1];

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int LO     = gi * SEG;      // first sum bit this stage resolves
        localparam int REM_IN = WIDTH - LO;    // operand bits still to be consumed

        logic [REM_IN-1:0]   opa;
        logic [REM_IN-1:0]   opb;
        logic                c_in_s;
        logic [SEG:0]        seg_res;
        logic [LO+SEG-1:0]   ps_next;
        logic                valid_reg;
        logic                load;

        if (gi == 0) begin : g_src
            // Subtract is A + ~B + 1; cin only matters for add.
            assign opa          = a;
            assign opb          = b ^ {WIDTH{sub}};
            assign c_in_s       = sub | cin;
            assign up_valid[gi] = in_valid;
            assign ps_next      = seg_res[SEG-1:0];
        end else begin : g_src
            assign opa          = g_stage[gi-1].g_hold.ra_reg;
            assign opb          = g_stage[gi-1].g_hold.rb_reg;
            assign c_in_s       = g_stage[gi-1].g_hold.c_reg;
            assign up_valid[gi] = valid_vec[gi-1];
            assign ps_next      = {seg_res[SEG-1:0], g_stage[gi-1].g_hold.ps_reg};
        end

        // One SEG-bit ripple per stage: the only arithmetic between registers.
        assign seg_res = {1'b0, opa[SEG-1:0]} + {1'b0, opb[SEG-1:0]} + {{SEG{1'b0}}, c_in_s};

        // Data registers only capture real bundles, never bubbles.
        assign load           = free_vec[gi] & up_valid[gi];
        assign valid_vec[gi]  = valid_reg;

        // Occupancy: refill (possibly with a bubble) whenever the slot frees up.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_reg <= 1'b0;
            end else if (free_vec[gi]) begin
                valid_reg <= up_valid[gi];
            end
        end

        if (gi < STAGES - 1) begin : g_hold
            localparam int REM_OUT = REM_IN - SEG;

            logic [REM_OUT-1:0] ra_reg;
            logic [REM_OUT-1:0] rb_reg;
            logic [LO+SEG-1:0]  ps_reg;
            logic               c_reg;

            // Forward remaining operand bits, partial sum and segment carry.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ra_reg <= '0;
                    rb_reg <= '0;
                    ps_reg <= '0;
                    c_reg  <= 1'b0;
                end else if (load) begin
                    ra_reg <= opa[REM_IN-1:SEG];
                    rb_reg <= opb[REM_IN-1:SEG];
                    ps_reg <= ps_next;
                    c_reg  <= seg_res[SEG];
                end
            end
        end else begin : g_last
            logic [WIDTH-1:0] sum_reg;
            logic             cout_reg;
            logic             ovf_reg;
            logic             zero_reg;

            // Final result and flags; held untouched while stalled or empty.
            // Here opa/opb are the top SEG bits, so bit SEG-1 is the sign.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sum_reg  <= '0;
                    cout_reg <= 1'b0;
                    ovf_reg  <= 1'b0;
                    zero_reg <= 1'b0;
                end else if (load) begin
                    sum_reg  <= ps_next;
                    cout_reg <= seg_res[SEG];
                    ovf_reg  <= (opa[SEG-1] == opb[SEG-1]) && (seg_res[SEG-1] != opa[SEG-1]);
                    zero_reg <= ~|ps_next;
                end
            end

            assign sum  = sum_reg;
            assign cout = cout_reg;
            assign ovf  = ovf_reg;
            assign zero = zero_reg;
        end
    end

endmodule

// File: tb/tb_add_sub_pipe.sv
// Testbench for add_sub_pipe: directed cases on a 32-bit/4-stage instance,
// then randomized streams on several (WIDTH, STAGES) configurations. Drivers
// push expected results into queues at each accepted transfer; monitors pop
// and compare whenever a result is consumed.
module tb_add_sub_pipe;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc_cyc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;
    bit sweep_go     = 1'b0;

    // Arithmetic reference: plain integer add/subtract on WIDTH-bit values,
    // unsigned for sum/carry, signed range test for overflow.
    function automatic exp_t model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                   input logic subv, input logic cinv);
        exp_t e;
        logic [127:0]        lim, mask, ua, ub, us;
        logic signed [127:0] sa, sb, ss, smax, smin;
        lim  = 128'(1) << w;
        mask = lim - 128'(1);
        ua   = {64'b0, av} & mask;
        ub   = {64'b0, bv} & mask;
        sa   = $signed(ua);
        sb   = $signed(ub);
        if (ua[w-1]) sa = $signed(ua - lim);
        if (ub[w-1]) sb = $signed(ub - lim);
        smax = $signed((lim >> 1) - 128'(1));
        smin = -$signed(lim >> 1);
        if (subv) begin
            us     = ua - ub;
            e.cout = (ua >= ub);
            ss     = sa - sb;
        end else begin
            us     = ua + ub + 128'(cinv);
            e.cout = (us >= lim);
            ss     = sa + sb;
            if (cinv) ss = ss + 1;
        end
        us      = us & mask;
        e.sum   = us[63:0];
        e.ovf   = (ss > smax) || (ss < smin);
        e.zero  = (e.sum == 64'd0);
        e.acc_cyc = 0;
        e.lat   = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [63:0] s, input logic c, input logic o, input logic z);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o; e.zero = z; e.acc_cyc = 0; e.lat = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: %s", name, what);
    endtask

    // ---------------- main instance: WIDTH=32, STAGES=4 ----------------
    logic        m_in_valid = 1'b0, m_in_ready, m_cin = 1'b0, m_sub = 1'b0;
    logic        m_out_valid, m_out_ready = 1'b1, m_cout, m_ovf, m_zero;
    logic [31:0] m_a = '0, m_b = '0, m_sum;
    exp_t        m_q[$];
    exp_t        m_e;
    int          m_accepts = 0;

    add_sub_pipe #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .a(m_a), .b(m_b), .cin(m_cin), .sub(m_sub),
        .out_valid(m_out_valid), .out_ready(m_out_ready),
        .sum(m_sum), .cout(m_cout), .ovf(m_ovf), .zero(m_zero)
    );

    always @(negedge clk) begin
        if (!rst && m_out_valid && m_out_ready) begin
            if (m_q.size() == 0) begin
                fail_now("main_unexpected", $sformatf("got sum=0x%08h, expected no output", m_sum));
            end else begin
                m_e = m_q.pop_front();
                $display("[TB] main txn sum=0x%08h cout=%0b ovf=%0b zero=%0b", m_sum, m_cout, m_ovf, m_zero);
                check("main_sum",  64'(m_sum),  m_e.sum);
                check("main_cout", 64'(m_cout), 64'(m_e.cout));
                check("main_ovf",  64'(m_ovf),  64'(m_e.ovf));
                check("main_zero", 64'(m_zero), 64'(m_e.zero));
                if (m_e.lat) check("main_latency", 64'(cyc - m_e.acc_cyc), 64'd4);
            end
        end
    end

    task automatic send(input logic [31:0] a_i, input logic [31:0] b_i, input logic sub_i,
                        input logic cin_i, input exp_t e_i);
        exp_t e;
        bit   done;
        e    = e_i;
        done = 1'b0;
        m_a = a_i; m_b = b_i; m_sub = sub_i; m_cin = cin_i;
        m_in_valid = 1'b1;
        for (int w = 0; w < 100 && !done; w++) begin
            @(negedge clk);
            if (m_in_ready) begin
                e.acc_cyc = cyc;
                m_q.push_back(e);
                m_accepts++;
                done = 1'b1;
            end
        end
        if (!done) fail_now("main_send_timeout", "in_ready stayed low for 100 cycles");
        @(posedge clk); #1;
        m_in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [31:0] a_i, input logic [31:0] b_i,
                              input logic sub_i, input logic cin_i);
        send(a_i, b_i, sub_i, cin_i, model(32, 64'(a_i), 64'(b_i), sub_i, cin_i));
    endtask

    task automatic drain();
        for (int w = 0; w < 60 && m_q.size() != 0; w++) @(negedge clk);
        check("main_drained", 64'(m_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- randomized configuration sweep ----------------
    for (genvar gi = 0; gi < 5; gi++) begin : g_sw
        localparam int W = (gi == 0) ? 32 : (gi == 1) ? 32 : (gi == 2) ? 64 : (gi == 3) ? 8 : 32;
        localparam int S = (gi == 0) ? 1  : (gi == 1) ? 32 : (gi == 2) ? 8  : (gi == 3) ? 2 : 4;

        logic         s_in_valid = 1'b0, s_in_ready, s_cin = 1'b0, s_sub = 1'b0;
        logic         s_out_valid, s_out_ready = 1'b0, s_cout, s_ovf, s_zero;
        logic [W-1:0] s_a = '0, s_b = '0, s_sum;
        exp_t         q[$];
        exp_t         e_drv, e_mon;
        bit           done = 1'b0;

        add_sub_pipe #(.WIDTH(W), .STAGES(S)) dut_sw (
            .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
            .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
            .out_valid(s_out_valid), .out_ready(s_out_ready),
            .sum(s_sum), .cout(s_cout), .ovf(s_ovf), .zero(s_zero)
        );

        function automatic logic [63:0] pick();
            case ($urandom_range(0, 7))
                0:       return 64'hFFFF_FFFF_FFFF_FFFF;
                1:       return 64'd0;
                2:       return 64'd1 << (W - 1);
                3:       return (64'd1 << (W - 1)) - 64'd1;
                default: return {$urandom, $urandom};
            endcase
        endfunction

        initial begin
            logic [63:0] ta, tb;
            wait (sweep_go);
            @(posedge clk); #1;
            for (int n = 0; n < 400; n++) begin
                ta = pick();
                tb = pick();
                s_a         = ta[W-1:0];
                s_b         = tb[W-1:0];
                s_sub       = 1'($urandom_range(0, 1));
                s_cin       = 1'($urandom_range(0, 1));
                s_in_valid  = ($urandom_range(0, 3) != 0);
                s_out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (s_in_valid && s_in_ready) begin
                    e_drv = model(W, 64'(s_a), 64'(s_b), s_sub, s_cin);
                    q.push_back(e_drv);
                end
                @(posedge clk); #1;
            end
            s_in_valid  = 1'b0;
            s_out_ready = 1'b1;
            for (int n = 0; n < 200 && q.size() != 0; n++) @(negedge clk);
            check($sformatf("w%0d_s%0d_drained", W, S), 64'(q.size()), 64'd0);
            done = 1'b1;
        end

        always @(negedge clk) begin
            if (!rst && s_out_valid && s_out_ready) begin
                if (q.size() == 0) begin
                    fail_now($sformatf("w%0d_s%0d_unexpected", W, S),
                             $sformatf("got sum=0x%0h, expected no output", s_sum));
                end else begin
                    e_mon = q.pop_front();
                    $display("[TB] w%0d_s%0d txn sum=0x%0h cout=%0b ovf=%0b zero=%0b",
                             W, S, s_sum, s_cout, s_ovf, s_zero);
                    check($sformatf("w%0d_s%0d_sum", W, S),  64'(s_sum),  e_mon.sum);
                    check($sformatf("w%0d_s%0d_cout", W, S), 64'(s_cout), 64'(e_mon.cout));
                    check($sformatf("w%0d_s%0d_ovf", W, S),  64'(s_ovf),  64'(e_mon.ovf));
                    check($sformatf("w%0d_s%0d_zero", W, S), 64'(s_zero), 64'(e_mon.zero));
                end
            end
        end
    end

    // ---------------- directed sequence, then sweep ----------------
    initial begin
        exp_t e;
        logic [31:0] held;
        bit          have;
        bit          seen_valid;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_out_valid", 64'(m_out_valid), 64'd0);
        check("rst_sum",       64'(m_sum),       64'd0);
        check("rst_cout",      64'(m_cout),      64'd0);
        check("rst_ovf",       64'(m_ovf),       64'd0);
        check("rst_zero",      64'(m_zero),      64'd0);
        check("rst_in_ready",  64'(m_in_ready),  64'd1);
        @(posedge clk); #1;

        // Signed overflow on add, with exact latency.
        e = mk(64'h8000_0000, 1'b0, 1'b1, 1'b0);
        e.lat = 1'b1;
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, e);
        drain();

        // Subtract cases (cin must be ignored), and a carry through every segment.
        send(32'd5, 32'd5, 1'b1, 1'b1, mk(64'h0, 1'b1, 1'b0, 1'b1));
        send(32'd3, 32'd5, 1'b1, 1'b0, mk(64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
        send(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, mk(64'h0, 1'b1, 1'b0, 1'b1));
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, mk(64'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
        drain();

        // Back-pressure: 10 back-to-back adds with the consumer stalled 6 cycles.
        m_accepts = 0;
        have      = 1'b0;
        fork
            begin
                m_out_ready = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    if (m_out_valid) begin
                        if (!have) begin
                            held = m_sum;
                            have = 1'b1;
                        end else begin
                            check("bp_hold_stable", 64'(m_sum), 64'(held));
                        end
                    end
                end
                check("bp_accepts_while_stalled", 64'(m_accepts), 64'd4);
                check("bp_in_ready_low", 64'(m_in_ready), 64'd0);
                check("bp_out_valid_high", 64'(m_out_valid), 64'd1);
                @(posedge clk); #1;
                m_out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 10; i++) send(32'(i), 32'(i), 1'b0, 1'b0, mk(64'(2 * i), 1'b0, 1'b0, (i == 0)));
            end
        join
        drain();

        // Reset with three results in flight: all are discarded.
        m_out_ready = 1'b0;
        send_model(32'd10, 32'd20, 1'b0, 1'b0);
        send_model(32'd30, 32'd40, 1'b0, 1'b0);
        send_model(32'd50, 32'd60, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_q.delete();
        @(negedge clk);
        check("midrst_out_valid", 64'(m_out_valid), 64'd0);
        check("midrst_sum",       64'(m_sum),       64'd0);
        m_out_ready = 1'b1;
        seen_valid  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (m_out_valid) seen_valid = 1'b1;
        end
        check("midrst_no_stale", 64'(seen_valid), 64'd0);
        @(posedge clk); #1;
        send(32'd1, 32'd1, 1'b0, 1'b0, mk(64'd2, 1'b0, 1'b0, 1'b0));
        drain();

        // Randomized sweep over configurations.
        sweep_go = 1'b1;
        for (int w = 0; w < 20000; w++) begin
            @(posedge clk);
            if (g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done && g_sw[4].done) break;
        end
        if (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done && g_sw[4].done))
            fail_now("sweep_timeout", "configuration sweep did not complete in 20000 cycles");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/add_sub_pipe.md
# add_sub_pipe

Parametrised, pipelined two's-complement adder/subtractor for the RISC-V datapath. It is the successor to the single-cycle 32-bit ripple-carry adder. The carry chain is split into STAGES equal segments, one segment resolved per pipeline stage, with a valid/ready handshake on both sides. It also adds a subtract mode and carry, overflow and zero flags, and it serves the ALU and the address-generation path at higher clock rates.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; legal range 1..WIDTH. Each stage resolves SEG = WIDTH/STAGES bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand bundle is presented.
- in_ready  output  1  block accepts the bundle this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  1 selects A − B; 0 selects A + B + cin.
- out_valid  output  1  result bundle is valid.
- out_ready  input  1  consumer takes the result this cycle.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH−1. For subtract, 1 means no borrow (A ≥ B unsigned).
- ovf  output  1  signed overflow.
- zero  output  1  sum == 0.

## Operation
- Accept: a transfer occurs on a cycle where in_valid && in_ready are both high at the clock edge. The block latches a, b ^ {WIDTH{sub}} and the effective carry-in (sub ? 1 : cin).
- Stage k (0..STAGES−1) adds segment bits [k·SEG +: SEG] with the carry from stage k−1. Stage k also forwards the unprocessed upper operand bits, the completed lower sum bits, the carry and the sign bits of the effective A and B.
- Last stage: computes the flags.
  - cout = final carry.
  - ovf = (A[W−1] == B'[W−1]) && (sum[W−1] != A[W−1]), where B' is the post-inversion operand.
  - zero = ~|sum.
- Each stage holds its own valid bit.
- Stage k loads when it is empty, or when its content moves to stage k+1 in the same cycle. For the last stage, "moves on" means out_valid && out_ready.
- in_ready = stage 0 empty, or stage 0 advancing this cycle. in_ready is combinational from the downstream valid bits and out_ready, never from in_valid.
- Stalling: while out_valid=1 and out_ready=0, the last stage holds sum, cout, ovf and zero stable. Upstream stages fill behind it. Once all STAGES slots are full, in_ready=0.
- Bubbles are allowed in any stage. Data order is strictly preserved, with no reordering or dropping.
- STAGES=1 degenerates to one registered full-width add with a single-entry skid.

## Timing
- Reset (rst=1 at the edge): all stage valid bits clear.
  - Output values after reset: out_valid=0, sum=0, cout=0, ovf=0, zero=0.
  - in_ready=1 from the first cycle after reset.
  - Reset takes priority over any simultaneous accept or consume.
  - Reset mid-operation discards all in-flight results, and no out_valid pulse follows.
- Latency: a bundle accepted at edge N is visible with out_valid=1 after edge N+STAGES−1, i.e. on the cycle immediately following STAGES edges, assuming no stall.
- Throughput: one result per cycle while out_ready=1.
- Simultaneous accept and consume with the pipe full: both happen, and occupancy is unchanged.
- Stable outputs: sum and flags only change on an edge where the last stage loads. When out_valid=0 they hold their last value.
- Critical path: one SEG-bit ripple plus handshake logic. No combinational path from a/b to any output.

## Test plan
- Add, WIDTH=32, STAGES=4:
  - a=0x7FFFFFFF, b=0x00000001, sub=0, cin=0 → sum=0x80000000, cout=0, ovf=1, zero=0, exactly 4 cycles after accept.
- Subtract:
  - a=5, b=5, sub=1 → sum=0, cout=1, zero=1, ovf=0.
  - a=3, b=5, sub=1 → sum=0xFFFFFFFE, cout=0, ovf=0.
- Carry across all segments: a=0xFFFFFFFF, b=0, cin=1 → sum=0, cout=1, zero=1. This checks carry propagation through every stage boundary.
- Back-pressure:
  - Stream 10 back-to-back adds (a=i, b=i) with out_ready held low for 6 cycles.
  - in_ready drops after 4 accepts.
  - Outputs then emerge in order as 0,2,…,18 with no loss or duplication.
  - The held output stays stable while stalled.
- Reset mid-stream: assert rst for 1 cycle while 3 results are in flight → out_valid=0 on the next cycle and no stale result ever appears. A following add 1+1 yields 2.
- Parameter sweep:
  - Configurations: (WIDTH,STAGES) = (32,1), (32,32), (64,8), (8,2).
  - Run random operands with random in_valid/out_ready.
  - Compare against a reference model of {cout,sum} = A + (B^sub) + cin_eff.
  - Check ovf/zero on every transfer.
